// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } hilo_state_t;

  // One radix-2 iteration per result bit.
  localparam int HILO_ITER = 32;

  function automatic logic op_is_div(input hilo_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input hilo_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_sequencer_if.sv
// Start/busy/done handshake and HI/LO result bus between the control unit and the sequencer.
interface hilo_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, DivZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, DivZero, Hi, Lo
  );
endinterface

// File: rtl/hilo_sequencer_step.sv
// One combinational iteration: shift-add multiply or restoring divide on unsigned magnitudes.
// Multiply layout: acc = {0, partial product high word, remaining multiplier bits}.
// Divide layout:   acc = {33-bit remainder, dividend bits shifting out / quotient bits shifting in}.
module hilo_step
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH:0]   acc_o
);

  logic [WIDTH:0] mul_upper;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;
  logic [WIDTH:0] rem_next;
  logic           q_bit;

  // Compute both algorithms' next value and select by op class.
  always_comb begin
    mul_upper = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Remainder stays below the divisor, so its top bit is free for the shift.
    rem_shift = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_i};
    q_bit     = ~rem_diff[WIDTH];
    rem_next  = q_bit ? rem_diff : rem_shift;
    if (is_div_i) begin
      acc_o = {rem_next, acc_i[WIDTH-2:0], q_bit};
    end else begin
      acc_o = {1'b0, mul_upper, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_sequencer.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
module hilo_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  hilo_sequencer_if.slave     bus
);

  localparam int AW    = 2 * WIDTH + 1;
  localparam int CNT_W = $clog2(HILO_ITER);

  hilo_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  hilo_op_t           op_q, op_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               divzero_q, divzero_d;

  logic [AW-1:0]      step_acc;
  hilo_op_t           op_in;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  hilo_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  // Next-state, operand latching on Start, iteration and sign fix-up.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;

    op_in = hilo_op_t'(bus.Op);
    a_neg = op_is_signed(op_in) & bus.A[WIDTH-1];
    b_neg = op_is_signed(op_in) & bus.B[WIDTH-1];
    a_mag = a_neg ? -bus.A : bus.A;
    b_mag = b_neg ? -bus.B : bus.B;
    prod  = qneg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quot  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (op_is_div(op_q)) begin
          lo_d = quot;
          hi_d = rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = DONE;
      end
      default: begin
        // IDLE and DONE both accept a new operation; DONE otherwise falls back to IDLE.
        if (state_q == DONE) begin
          state_d   = IDLE;
          divzero_d = 1'b0;
        end
        if (bus.Start) begin
          op_d      = op_in;
          divzero_d = 1'b0;
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          if (op_is_div(op_in) && (bus.B == '0)) begin
            state_d   = DONE;
            divzero_d = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(HILO_ITER - 1);
            if (op_is_div(op_in)) begin
              acc_d  = {{(WIDTH+1){1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{(WIDTH+1){1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end
        end
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      divzero_q <= divzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Datapath registers: latched operands, signs, counter and accumulator.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q  <= '0;
      op_q   <= MULT;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
    end
  end

  assign bus.Busy    = (state_q == CALC) || (state_q == FIX);
  assign bus.Done    = (state_q == DONE);
  assign bus.DivZero = divzero_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;

endmodule

// File: doc/hilo_sequencer.md
# hilo_sequencer

Multi-cycle multiply/divide unit with architectural HI/LO registers for the multicycle MIPS core. The control unit pulses `Start` with an opcode; the block latches the A/B register outputs and runs a radix-2 iterative algorithm for 32 cycles. It then writes HI/LO and signals completion with a one-cycle `Done`. It replaces the state-number-driven multiplier with an explicit start/busy/done handshake, and adds divide support.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Results are 2×WIDTH, split into HI and LO.

Ports:
- `Clk`, in, 1: the block's only clock.
- `Reset`, in, 1: asynchronous, active-low. Clears all state and HI/LO.
- `Start`, in, 1: launches an operation. Accepted only in IDLE or DONE.
- `Op`, in, 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A`, in, WIDTH: multiplicand or dividend. Sampled at the Start edge.
- `B`, in, WIDTH: multiplier or divisor. Sampled at the Start edge.
- `Busy`, out, 1: high while in CALC or FIX.
- `Done`, out, 1: one-cycle pulse; HI/LO are valid when it is high.
- `DivZero`, out, 1: valid with `Done`. High when a DIV or DIVU had B == 0.
- `Hi`, out, WIDTH: HI register.
- `Lo`, out, WIDTH: LO register.

## Operation
- States:
  - IDLE → CALC on `Start`.
  - IDLE → DONE on `Start` when the op is DIV or DIVU and B == 0.
  - CALC → FIX after 32 iterations.
  - FIX → DONE.
  - DONE → IDLE, or DONE → CALC/DONE if `Start` is high in DONE.
- Start: the op and operand magnitudes are latched. Signed ops take the two's-complement absolute value. The result sign is recorded:
  - MULT: sign is A[31] XOR B[31].
  - DIV: quotient sign is A[31] XOR B[31]; remainder sign is A[31].
- Operands on `A` and `B` may change freely after the Start edge.
- CALC, multiply: 32 shift-add steps on a 64-bit accumulator. The iteration counter runs from 31 down to 0.
- CALC, divide: 32 restoring steps. The remainder is 33 bits; the quotient shifts into the low word.
- FIX: apply sign correction, then write `Hi` and `Lo`.
  - Multiply: `Hi` = product[63:32], `Lo` = product[31:0].
  - Divide: `Lo` = quotient, `Hi` = remainder. Quotient truncates toward zero.
- 0x80000000 / −1 (DIV) gives `Lo` = 0x80000000, `Hi` = 0. No trap; this falls out of the 32-bit magnitude arithmetic.
- Divide by zero: no iterations run. `Hi` and `Lo` are left unchanged, and `DivZero` = 1 with `Done`.
- `Hi` and `Lo` change only in FIX (or on reset). They hold between operations.
- `Start` while `Busy` is ignored: no effect and no queuing.
- Reset mid-operation: the FSM returns to IDLE immediately; `Hi`, `Lo`, `Busy`, `Done` and `DivZero` go to 0. No `Done` is produced for the aborted operation.

## Timing
- Reset values: state IDLE; `Busy` = 0, `Done` = 0, `DivZero` = 0, `Hi` = 0, `Lo` = 0.
- Let edge 0 be the edge that samples `Start` = 1.
  - Normal op: `Busy` = 1 from after edge 0 through edge 33 (32 CALC cycles, then 1 FIX cycle).
  - `Hi`/`Lo` update at edge 33.
  - `Done` = 1 during the cycle after edge 33, i.e. 34 cycles after the Start edge.
- Divide by zero: `Done` = 1 and `DivZero` = 1 in the cycle right after edge 0. `Busy` stays 0.
- Back-to-back: `Start` held during DONE is accepted. The next operation's first CALC cycle immediately follows the DONE cycle.
- All outputs are registered. Nothing depends combinationally on inputs.

## Structure
- Package `hilo_pkg` holds:
  - `hilo_op_t` enum: MULT, MULTU, DIV, DIVU.
  - `hilo_state_t` enum: IDLE, CALC, FIX, DONE.
  - `HILO_ITER` = 32.
- One sub-module, `hilo_step`: combinational single iteration. Inputs are the op class, the accumulator/remainder and the operand. Outputs are the next accumulator/remainder. `hilo_sequencer` owns the FSM, counter, sign flags, HI/LO and handshake.

## Test plan
- MULT, A = 0xFFFFFFFD (−3), B = 7 → `Done` at cycle 34; `Hi` = 0xFFFFFFFF, `Lo` = 0xFFFFFFEB.
- MULTU, A = B = 0xFFFFFFFF → `Hi` = 0xFFFFFFFE, `Lo` = 0x00000001; `Busy` high for exactly 33 cycles.
- DIV −7 / 2 → `Lo` = 0xFFFFFFFD, `Hi` = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `Lo` = 0x80000000, `Hi` = 0.
- DIVU A = 100, B = 0, with prior `Hi` = 0x11, `Lo` = 0x22 → `Done` = 1 and `DivZero` = 1 one cycle after Start; `Hi` = 0x11 and `Lo` = 0x22 unchanged.
- MULT started, then `Start` pulsed with DIV at CALC cycle 5, and `A` changed at cycle 6 → second Start ignored; result equals the original MULT of the latched operands.
- `Reset` = 0 at CALC cycle 10 → `Busy`, `Hi`, `Lo` = 0 at once and no `Done`. After release, MULTU 3 × 5 → `Lo` = 15 at cycle 34.
